mac_rx_traffic_checker: RTL and testbench

MAC_RX_TRAFFIC_CHECKER -- requirements
Module: mac_rx_traffic_checker

---
 rtl/mac_chk_pkg.sv | 27 ++
 rtl/mac_chk_beat_check.sv | 33 +++
 rtl/mac_rx_traffic_checker.sv | 190 +++++++++++++++++++
 tb/tb_mac_rx_traffic_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_chk_pkg.sv
// rtl/mac_chk_pkg.sv - shared FSM state type and completion status codes for the MAC RX traffic checker
package mac_chk_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOCK,
        S_RECV,
        S_DRAIN,
        S_DONE
    } chk_state_e;

    localparam logic [4:0] STAT_BUSY          = 5'd0;
    localparam logic [4:0] STAT_PASS          = 5'd1;
    localparam logic [4:0] STAT_LOCK_TIMEOUT  = 5'd2;
    localparam logic [4:0] STAT_LOST_LOCK     = 5'd4;
    localparam logic [4:0] STAT_NO_PKTS       = 5'd11;
    localparam logic [4:0] STAT_PKT_MISMATCH  = 5'd12;
    localparam logic [4:0] STAT_BYTE_MISMATCH = 5'd13;
    localparam logic [4:0] STAT_PROTOCOL      = 5'd14;
    localparam logic [4:0] STAT_DATA_ERR      = 5'd15;
    localparam logic [4:0] STAT_RESET         = 5'd31;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mac_chk_beat_check.sv
// rtl/mac_chk_beat_check.sv - per-beat lane pattern compare, tkeep validation and kept-byte popcount
module mac_chk_beat_check
    import mac_chk_pkg::*;
(
    input  logic [63:0] tdata_i,
    input  logic [7:0]  tkeep_i,
    input  logic        tlast_i,
    input  logic [7:0]  exp_base_i,
    output logic        lane_mismatch_o,
    output logic        keep_err_o,
    output logic [3:0]  popcount_o
);

    logic keep_contig;

    always_comb begin
        lane_mismatch_o = 1'b0;
        popcount_o      = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (tkeep_i[k] && (tdata_i[8*k +: 8] != (exp_base_i + 8'(k)))) begin
                lane_mismatch_o = 1'b1;
            end
            popcount_o = popcount_o + {3'd0, tkeep_i[k]};
        end
    end

    // A run of ones starting at bit 0 turns into a single carry when incremented.
    assign keep_contig = ((tkeep_i & (tkeep_i + 8'd1)) == 8'd0);

    assign keep_err_o = (tkeep_i == 8'd0) || !keep_contig ||
                        (!tlast_i && (tkeep_i != 8'hFF));

endmodule

// File: rtl/mac_rx_traffic_checker.sv
// rtl/mac_rx_traffic_checker.sv - checks a run of patterned MAC RX packets and reports a completion code
module mac_rx_traffic_checker
    import mac_chk_pkg::*;
#(
    parameter int NUM_PKTS     = 16,
    parameter int PKT_BYTES    = 64,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int RX_TIMEOUT   = 1048576,
    parameter int DRAIN_CYCLES = 256
) (
    input  logic        dclk,
    input  logic        sys_reset,
    input  logic        start,
    input  logic        rx_block_lock,
    input  logic        rx_axis_tvalid,
    input  logic [63:0] rx_axis_tdata,
    input  logic [7:0]  rx_axis_tkeep,
    input  logic        rx_axis_tlast,
    input  logic        rx_axis_tuser,
    output logic        rx_axis_tready,
    output logic [15:0] pkt_cnt,
    output logic [31:0] byte_cnt,
    output logic [15:0] err_cnt,
    output logic        done,
    output logic [4:0]  completion_status
);

    localparam logic [31:0] LOCK_LIM    = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] RX_LIM      = 32'(RX_TIMEOUT - 1);
    localparam logic [31:0] DRAIN_LIM   = 32'(DRAIN_CYCLES - 1);
    localparam logic [15:0] PKT_TARGET  = 16'(NUM_PKTS);
    localparam logic [31:0] BYTE_TARGET = 32'(NUM_PKTS * PKT_BYTES);

    chk_state_e  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        prot_err_q, prot_err_d;
    logic [7:0]  pkt_idx_q, pkt_idx_d;
    logic [7:0]  byte_off_q, byte_off_d;
    logic [4:0]  status_q, status_d;

    logic       accept;
    logic       run_clear;
    logic       lost_lock;
    logic       final_tlast;
    logic       lane_mismatch;
    logic       keep_err;
    logic [3:0] popcount;

    mac_chk_beat_check u_beat_check (
        .tdata_i         (rx_axis_tdata),
        .tkeep_i         (rx_axis_tkeep),
        .tlast_i         (rx_axis_tlast),
        .exp_base_i      (pkt_idx_q + byte_off_q),
        .lane_mismatch_o (lane_mismatch),
        .keep_err_o      (keep_err),
        .popcount_o      (popcount)
    );

    assign accept      = rx_axis_tvalid && rx_axis_tready;
    assign run_clear   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign lost_lock   = ((state_q == S_RECV) || (state_q == S_DRAIN)) && !rx_block_lock;
    assign final_tlast = (state_q == S_RECV) && accept && rx_axis_tlast && (pkt_cnt_d == PKT_TARGET);

    always_ff @(posedge dclk) begin
        if (sys_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (rx_block_lock)          state_d = S_RECV;
                else if (timer_q >= LOCK_LIM) state_d = S_DONE;
            end
            S_RECV: begin
                if (lost_lock)                            state_d = S_DONE;
                else if (final_tlast)                     state_d = S_DRAIN;
                else if (!accept && (timer_q >= RX_LIM))  state_d = S_DONE;
            end
            S_DRAIN: begin
                if (lost_lock || (timer_q >= DRAIN_LIM)) state_d = S_DONE;
            end
            S_DONE: begin
                if (start) state_d = S_WAIT_LOCK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_axis_tready    = (state_q == S_RECV) || (state_q == S_DRAIN);
        done              = (state_q == S_DONE);
        completion_status = (state_q == S_DONE) ? status_q : STAT_BUSY;
        // Reset code is driven straight from the reset pin so it shows before any edge.
        if (sys_reset) completion_status = STAT_RESET;
    end

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        byte_cnt_d = byte_cnt_q;
        err_cnt_d  = err_cnt_q;
        prot_err_d = prot_err_q;
        pkt_idx_d  = pkt_idx_q;
        byte_off_d = byte_off_q;
        if (run_clear) begin
            pkt_cnt_d  = 16'd0;
            byte_cnt_d = 32'd0;
            err_cnt_d  = 16'd0;
            prot_err_d = 1'b0;
            pkt_idx_d  = 8'd0;
            byte_off_d = 8'd0;
        end else if (accept) begin
            byte_cnt_d = byte_cnt_q + {28'd0, popcount};
            if (lane_mismatch || (rx_axis_tuser && rx_axis_tlast)) begin
                err_cnt_d = sat_inc16(err_cnt_q);
            end
            if (keep_err) prot_err_d = 1'b1;
            if (rx_axis_tlast) begin
                pkt_cnt_d  = sat_inc16(pkt_cnt_q);
                pkt_idx_d  = pkt_idx_q + 8'd1;
                byte_off_d = 8'd0;
            end else begin
                byte_off_d = byte_off_q + 8'd8;
            end
        end
    end

    // One timer serves lock wait, RX idle and drain; it restarts on every state change.
    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || run_clear) begin
            timer_d = 32'd0;
        end else if ((state_q == S_RECV) && accept) begin
            timer_d = 32'd0;
        end else if ((state_q == S_WAIT_LOCK) || (state_q == S_RECV) || (state_q == S_DRAIN)) begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_comb begin
        status_d = status_q;
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            if (lost_lock)                       status_d = STAT_LOST_LOCK;
            else if (state_q == S_WAIT_LOCK)     status_d = STAT_LOCK_TIMEOUT;
            else if (prot_err_d)                 status_d = STAT_PROTOCOL;
            else if (err_cnt_d != 16'd0)         status_d = STAT_DATA_ERR;
            else if (pkt_cnt_d == 16'd0)         status_d = STAT_NO_PKTS;
            else if (pkt_cnt_d != PKT_TARGET)    status_d = STAT_PKT_MISMATCH;
            else if (byte_cnt_d != BYTE_TARGET)  status_d = STAT_BYTE_MISMATCH;
            else                                 status_d = STAT_PASS;
        end
    end

    always_ff @(posedge dclk) begin
        if (sys_reset) begin
            timer_q    <= 32'd0;
            pkt_cnt_q  <= 16'd0;
            byte_cnt_q <= 32'd0;
            err_cnt_q  <= 16'd0;
            prot_err_q <= 1'b0;
            pkt_idx_q  <= 8'd0;
            byte_off_q <= 8'd0;
            status_q   <= STAT_BUSY;
        end else begin
            timer_q    <= timer_d;
            pkt_cnt_q  <= pkt_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            err_cnt_q  <= err_cnt_d;
            prot_err_q <= prot_err_d;
            pkt_idx_q  <= pkt_idx_d;
            byte_off_q <= byte_off_d;
            status_q   <= status_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign byte_cnt = byte_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mac_rx_traffic_checker.sv
// tb/tb_mac_rx_traffic_checker.sv - directed self-checking bench for mac_rx_traffic_checker
module tb_mac_rx_traffic_checker;

    logic        dclk = 1'b0;
    logic        sys_reset;
    logic        start;
    logic        rx_block_lock;
    logic        rx_axis_tvalid;
    logic [63:0] rx_axis_tdata;
    logic [7:0]  rx_axis_tkeep;
    logic        rx_axis_tlast;
    logic        rx_axis_tuser;
    logic        rx_axis_tready;
    logic [15:0] pkt_cnt;
    logic [31:0] byte_cnt;
    logic [15:0] err_cnt;
    logic        done;
    logic [4:0]  completion_status;

    int tests_run = 0;
    int tests_failed = 0;
    int cycles;

    always #5 dclk = ~dclk;

    mac_rx_traffic_checker #(
        .NUM_PKTS     (16),
        .PKT_BYTES    (64),
        .LOCK_TIMEOUT (100),
        .RX_TIMEOUT   (50),
        .DRAIN_CYCLES (20)
    ) dut (
        .dclk              (dclk),
        .sys_reset         (sys_reset),
        .start             (start),
        .rx_block_lock     (rx_block_lock),
        .rx_axis_tvalid    (rx_axis_tvalid),
        .rx_axis_tdata     (rx_axis_tdata),
        .rx_axis_tkeep     (rx_axis_tkeep),
        .rx_axis_tlast     (rx_axis_tlast),
        .rx_axis_tuser     (rx_axis_tuser),
        .rx_axis_tready    (rx_axis_tready),
        .pkt_cnt           (pkt_cnt),
        .byte_cnt          (byte_cnt),
        .err_cnt           (err_cnt),
        .done              (done),
        .completion_status (completion_status)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int p, input int b);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'((p + b*8 + k) & 255);
        return d;
    endfunction

    task automatic start_run(input int lock_delay);
        rx_block_lock = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (lock_delay) tick();
        rx_block_lock = 1'b1;
        tick();
    endtask

    task automatic send_pkt(input int p, input int bad_byte, input int short_beat, input bit drop_lock_last);
        for (int b = 0; b < 8; b++) begin
            rx_axis_tvalid = 1'b1;
            rx_axis_tdata  = pat(p, b);
            if (bad_byte >= 0 && (bad_byte / 8) == b)
                rx_axis_tdata[(bad_byte % 8)*8 +: 8] = rx_axis_tdata[(bad_byte % 8)*8 +: 8] ^ 8'hFF;
            rx_axis_tkeep  = (b == short_beat) ? 8'h0F : 8'hFF;
            rx_axis_tlast  = (b == 7);
            rx_axis_tuser  = 1'b0;
            if (drop_lock_last && b == 7) rx_block_lock = 1'b0;
            tick();
        end
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 500; i++) begin
            if (done) break;
            tick();
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        sys_reset = 1'b1;
        start = 1'b0;
        rx_block_lock = 1'b0;
        rx_axis_tvalid = 1'b0;
        rx_axis_tdata = 64'd0;
        rx_axis_tkeep = 8'd0;
        rx_axis_tlast = 1'b0;
        rx_axis_tuser = 1'b0;
        #1;
        check("rst_status_async", {27'd0, completion_status}, 32'h1F);
        repeat (3) tick();
        check("rst_status", {27'd0, completion_status}, 32'h1F);
        check("rst_tready", {31'd0, rx_axis_tready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pkt", {16'd0, pkt_cnt}, 32'd0);
        check("rst_byte", byte_cnt, 32'd0);
        sys_reset = 1'b0;
        tick();
        check("post_rst_status", {27'd0, completion_status}, 32'd0);

        // good run
        start_run(10);
        check("recv_tready", {31'd0, rx_axis_tready}, 32'd1);
        check("recv_status", {27'd0, completion_status}, 32'd0);
        send_pkt(0, -1, -1, 1'b0);
        check("lat_pkt", {16'd0, pkt_cnt}, 32'd1);
        check("lat_byte", byte_cnt, 32'd64);
        for (int p = 1; p < 16; p++) send_pkt(p, -1, -1, 1'b0);
        check("drain_status", {27'd0, completion_status}, 32'd0);
        check("drain_tready", {31'd0, rx_axis_tready}, 32'd1);
        wait_done("good");
        check("good_pkt", {16'd0, pkt_cnt}, 32'd16);
        check("good_byte", byte_cnt, 32'd1024);
        check("good_err", {16'd0, err_cnt}, 32'd0);
        check("good_status", {27'd0, completion_status}, 32'd1);

        // byte 5 of packet 3 corrupted
        start_run(2);
        for (int p = 0; p < 16; p++) send_pkt(p, (p == 3) ? 5 : -1, -1, 1'b0);
        wait_done("corrupt");
        check("corrupt_err", {16'd0, err_cnt}, 32'd1);
        check("corrupt_pkt", {16'd0, pkt_cnt}, 32'd16);
        check("corrupt_status", {27'd0, completion_status}, 32'd15);

        // lock never arrives
        rx_block_lock = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            cycles++;
            if (done) break;
        end
        check("lockto_cycles", cycles, 32'd100);
        check("lockto_status", {27'd0, completion_status}, 32'd2);

        // only 15 packets
        start_run(3);
        for (int p = 0; p < 15; p++) send_pkt(p, -1, -1, 1'b0);
        wait_done("short");
        check("short_pkt", {16'd0, pkt_cnt}, 32'd15);
        check("short_byte", byte_cnt, 32'd960);
        check("short_status", {27'd0, completion_status}, 32'd12);

        // zero packets
        start_run(3);
        wait_done("zero");
        check("zero_pkt", {16'd0, pkt_cnt}, 32'd0);
        check("zero_status", {27'd0, completion_status}, 32'd11);

        // tkeep 0x0F on a non-last beat
        start_run(1);
        for (int p = 0; p < 16; p++) send_pkt(p, -1, (p == 0) ? 2 : -1, 1'b0);
        wait_done("keep");
        check("keep_byte", byte_cnt, 32'd1020);
        check("keep_err", {16'd0, err_cnt}, 32'd0);
        check("keep_status", {27'd0, completion_status}, 32'd14);

        // lock lost mid-packet
        start_run(1);
        for (int b = 0; b < 3; b++) begin
            rx_axis_tvalid = 1'b1;
            rx_axis_tdata  = pat(0, b);
            rx_axis_tkeep  = 8'hFF;
            rx_axis_tlast  = 1'b0;
            tick();
        end
        rx_axis_tvalid = 1'b0;
        rx_block_lock = 1'b0;
        tick();
        check("lost_done", {31'd0, done}, 32'd1);
        check("lost_byte", byte_cnt, 32'd24);
        check("lost_status", {27'd0, completion_status}, 32'd4);

        // lock lost together with the final tlast
        start_run(1);
        for (int p = 0; p < 15; p++) send_pkt(p, -1, -1, 1'b0);
        send_pkt(15, -1, -1, 1'b1);
        check("simul_done", {31'd0, done}, 32'd1);
        check("simul_pkt", {16'd0, pkt_cnt}, 32'd16);
        check("simul_status", {27'd0, completion_status}, 32'd4);

        // reset during RECV
        start_run(1);
        send_pkt(0, -1, -1, 1'b0);
        send_pkt(1, -1, -1, 1'b0);
        sys_reset = 1'b1;
        #1;
        check("midrst_status", {27'd0, completion_status}, 32'h1F);
        tick();
        tick();
        check("midrst_status_hold", {27'd0, completion_status}, 32'h1F);
        sys_reset = 1'b0;
        tick();
        check("midrst_rel_status", {27'd0, completion_status}, 32'd0);
        check("midrst_pkt", {16'd0, pkt_cnt}, 32'd0);
        check("midrst_byte", byte_cnt, 32'd0);
        check("midrst_err", {16'd0, err_cnt}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_tready", {31'd0, rx_axis_tready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
